// File: rtl/la_capture_sequencer_if.sv
// Control/status bundle for the logic-analyser capture sequencer.
// The master side arms and aborts captures and supplies the trigger; the
// slave side (the sequencer) reports state, ring-buffer pointers and the
// sample-memory write strobe.
interface la_capture_sequencer_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  request_start;
  logic                  request_stop;
  logic [1:0]            trigger_mode;
  logic [ADDR_WIDTH-1:0] trigger_loc;
  logic                  trig;
  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] read_pointer;
  logic [ADDR_WIDTH:0]   fill;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic                  bram_we;
  logic                  timed_out;

  modport master (
    output request_start, request_stop, trigger_mode, trigger_loc, trig,
    input  state, read_pointer, fill, bram_addr, bram_we, timed_out
  );

  modport slave (
    input  request_start, request_stop, trigger_mode, trigger_loc, trig,
    output state, read_pointer, fill, bram_addr, bram_we, timed_out
  );
endinterface

// File: rtl/la_capture_sequencer.sv
// Logic-analyser capture sequencer: walks a ring buffer of SAMPLE_DEPTH
// samples, keeps trigger_loc pre-trigger samples, then fills the remainder
// after the trigger. Optional macro LA_TIMEOUT_EN adds a forced trigger after
// TIMEOUT_CYCLES cycles waiting in IN_POSITION; without it timed_out is 0.
module la_capture_sequencer #(
  parameter int SAMPLE_DEPTH   = 1024,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                   clk,
  input logic                   rst,
  la_capture_sequencer_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(SAMPLE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLE_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   FULL      = (ADDR_WIDTH + 1)'(SAMPLE_DEPTH);

  typedef enum logic [2:0] {
    IDLE             = 3'd0,
    MOVE_TO_POSITION = 3'd1,
    IN_POSITION      = 3'd2,
    CAPTURING        = 3'd3,
    CAPTURED         = 3'd4
  } seq_state_t;

  seq_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] loc_q, loc_d;
  logic                  start_d1, stop_d1;

  logic                  start_edge, stop_edge, start_accept;
  logic                  writing, trig_fire, timeout_hit;
  logic [ADDR_WIDTH-1:0] clamp_loc, wr_ptr_inc, rd_ptr_inc;
  logic [ADDR_WIDTH:0]   fill_inc;

  // Request edges are taken against delayed copies that come out of reset
  // high, so a request held through reset is not mistaken for a new one.
  assign start_edge   = bus.request_start & ~start_d1;
  assign stop_edge    = bus.request_stop & ~stop_d1;
  assign start_accept = start_edge & ~stop_edge &
                        ((state_q == IDLE) | (state_q == CAPTURED));

  // A stop edge or reset suppresses the write of the cycle it arrives in.
  assign writing = ((state_q == MOVE_TO_POSITION) | (state_q == IN_POSITION) |
                    (state_q == CAPTURING)) & ~stop_edge & ~rst;

  assign clamp_loc  = (bus.trigger_loc > LAST_ADDR) ? LAST_ADDR : bus.trigger_loc;
  assign wr_ptr_inc = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
  assign rd_ptr_inc = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
  assign fill_inc   = fill_q + 1'b1;
  assign trig_fire  = bus.trig | timeout_hit;

`ifdef LA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;
  logic          timed_out_q;

  assign timeout_hit = (state_q == IN_POSITION) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign bus.timed_out = timed_out_q;

  // Count consecutive IN_POSITION cycles and remember a forced trigger until re-armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q    <= '0;
      timed_out_q <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == IN_POSITION) ? to_cnt_q + 1'b1 : '0;
      if (start_accept)
        timed_out_q <= 1'b0;
      else if (timeout_hit && !bus.trig && writing)
        timed_out_q <= 1'b1;
    end
  end
`else
  // Keeps the timeout parameter referenced when the feature is compiled out.
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign timeout_hit   = 1'b0;
  assign bus.timed_out = 1'b0;
`endif

  // Next-state and pointer/fill update: stop beats start, start re-arms, writes advance.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    loc_d    = loc_q;
    if (stop_edge) begin
      state_d = IDLE;
    end else if (start_accept) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
      loc_d    = clamp_loc;
      if (bus.trigger_mode == 2'd1)
        state_d = CAPTURING;
      else if (clamp_loc == '0)
        state_d = IN_POSITION;
      else
        state_d = MOVE_TO_POSITION;
    end else if (writing) begin
      wr_ptr_d = wr_ptr_inc;
      case (state_q)
        MOVE_TO_POSITION: begin
          fill_d = fill_inc;
          if (fill_inc == {1'b0, loc_q})
            state_d = IN_POSITION;
        end
        IN_POSITION: begin
          if (trig_fire) begin
            fill_d  = fill_inc;
            state_d = (fill_inc == FULL) ? CAPTURED : CAPTURING;
          end else begin
            rd_ptr_d = rd_ptr_inc;
          end
        end
        CAPTURING: begin
          fill_d = fill_inc;
          if (fill_inc == FULL)
            state_d = CAPTURED;
        end
        default: ;
      endcase
    end
  end

  // State, pointer and request-history registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      loc_q    <= '0;
      start_d1 <= 1'b1;
      stop_d1  <= 1'b1;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      loc_q    <= loc_d;
      start_d1 <= bus.request_start;
      stop_d1  <= bus.request_stop;
    end
  end

  assign bus.state        = state_q;
  assign bus.read_pointer = rd_ptr_q;
  assign bus.fill         = fill_q;
  assign bus.bram_addr    = wr_ptr_q;
  assign bus.bram_we      = writing;
endmodule

// File: tb/tb_la_capture_sequencer.sv
// Self-checking bench for la_capture_sequencer with SAMPLE_DEPTH=8 and
// TIMEOUT_CYCLES=20. Expected write streams and final pointers come from a
// transaction-level model: a capture writes consecutive addresses from 0,
// and the read pointer ends up at the number of fill-neutral writes.
module tb_la_capture_sequencer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TMO   = 20;
  localparam int BOUND = 200;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  la_capture_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  la_capture_sequencer #(
    .SAMPLE_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Arms one capture, lets it run to CAPTURED and compares it with the model.
  // k is the number of trig-low IN_POSITION cycles before the trigger cycle.
  task automatic applyStimulus(input int mode, input int loc, input int k, input bit useTrig);
    int eff, expWrites, expRp, cycles, moveCnt, inposCnt, trigAddr;
    bit imm;
    int got[$];
    imm = (mode == 1);
    eff = (loc > DEPTH - 1) ? DEPTH - 1 : loc;
    expWrites = imm ? DEPTH : k + DEPTH;
    expRp     = imm ? 0 : k % DEPTH;

    @(negedge clk);
    bus.trigger_mode  = mode[1:0];
    bus.trigger_loc   = loc[AW-1:0];
    bus.trig          = 1'b0;
    bus.request_start = 1'b1;
    @(negedge clk);
    bus.request_start = 1'b0;
    bus.trigger_mode  = 2'($urandom);
    bus.trigger_loc   = AW'($urandom);

    cycles = 0; moveCnt = 0; inposCnt = 0; trigAddr = -1;
    while (bus.state != 3'd4 && cycles < BOUND) begin
      if (bus.state == 3'd2) begin
        bus.trig = useTrig && (inposCnt == k);
        if (inposCnt == k) trigAddr = int'(bus.bram_addr);
        inposCnt++;
      end else begin
        bus.trig = 1'($urandom);
      end
      if (bus.state == 3'd1) moveCnt++;
      if (bus.bram_we) got.push_back(int'(bus.bram_addr));
      @(negedge clk);
      cycles++;
    end
    bus.trig = 1'b0;

    checkOutput("capture_within_bound", int'(cycles < BOUND), 1);
    checkOutput("final_state", int'(bus.state), 4);
    checkOutput("write_count", got.size(), expWrites);
    for (int i = 0; i < got.size() && i < expWrites; i++)
      checkOutput($sformatf("write_addr[%0d]", i), got[i], i % DEPTH);
    checkOutput("move_cycles", moveCnt, imm ? 0 : eff);
    checkOutput("inpos_cycles", inposCnt, imm ? 0 : k + 1);
    checkOutput("final_fill", int'(bus.fill), DEPTH);
    checkOutput("final_read_pointer", int'(bus.read_pointer), expRp);
    checkOutput("final_write_pointer", int'(bus.bram_addr), expRp);
    checkOutput("timed_out", int'(bus.timed_out), int'(!useTrig));
    if (!imm)
      checkOutput("trigger_sample_addr", trigAddr, (expRp + eff) % DEPTH);
    repeat (2) @(negedge clk);
    checkOutput("hold_fill", int'(bus.fill), DEPTH);
    checkOutput("hold_read_pointer", int'(bus.read_pointer), expRp);
    checkOutput("hold_no_write", int'(bus.bram_we), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.request_start = 1'b0;
    bus.request_stop  = 1'b0;
    bus.trigger_mode  = 2'd0;
    bus.trigger_loc   = '0;
    bus.trig          = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", int'(bus.state), 0);
    checkOutput("reset_fill", int'(bus.fill), 0);
    checkOutput("reset_read_pointer", int'(bus.read_pointer), 0);
    checkOutput("reset_bram_addr", int'(bus.bram_addr), 0);
    checkOutput("reset_bram_we", int'(bus.bram_we), 0);
    checkOutput("reset_timed_out", int'(bus.timed_out), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed scenarios: pre-trigger 3 with 5 waits, immediate, max and zero pre-trigger.
    applyStimulus(0, 3, 5, 1'b1);
    applyStimulus(1, 4, 0, 1'b1);
    applyStimulus(0, 7, 2, 1'b1);
    applyStimulus(0, 0, 3, 1'b1);
    applyStimulus(3, 2, 1, 1'b1);

    // Randomised captures.
    for (int n = 0; n < 8; n++)
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 6)), 1'b1);

    // Stop two cycles into CAPTURING, arriving together with a start edge.
    @(negedge clk);
    bus.trigger_mode  = 2'd1;
    bus.request_start = 1'b1;
    @(negedge clk);
    bus.request_start = 1'b0;
    checkOutput("stop_setup_capturing", int'(bus.state), 3);
    repeat (2) @(negedge clk);
    checkOutput("stop_setup_fill", int'(bus.fill), 2);
    bus.request_stop  = 1'b1;
    bus.request_start = 1'b1;
    @(negedge clk);
    checkOutput("stop_state", int'(bus.state), 0);
    checkOutput("stop_bram_we", int'(bus.bram_we), 0);
    checkOutput("stop_fill_held", int'(bus.fill), 2);
    checkOutput("stop_write_pointer_held", int'(bus.bram_addr), 2);
    checkOutput("stop_read_pointer_held", int'(bus.read_pointer), 0);
    bus.request_stop  = 1'b0;
    bus.request_start = 1'b0;
    @(negedge clk);
    bus.request_stop  = 1'b1;
    bus.request_start = 1'b1;
    @(negedge clk);
    checkOutput("stop_beats_start_in_idle", int'(bus.state), 0);
    checkOutput("stop_beats_start_fill", int'(bus.fill), 2);
    bus.request_stop  = 1'b0;
    bus.request_start = 1'b0;

    // Reset in MOVE_TO_POSITION, with start held high across reset.
    @(negedge clk);
    bus.trigger_mode  = 2'd0;
    bus.trigger_loc   = 3'd5;
    bus.request_start = 1'b1;
    @(negedge clk);
    bus.request_start = 1'b0;
    checkOutput("rst_setup_move", int'(bus.state), 1);
    @(negedge clk);
    rst = 1'b1;
    bus.request_start = 1'b1;
    #1;
    checkOutput("bram_we_during_rst", int'(bus.bram_we), 0);
    @(negedge clk);
    checkOutput("rst_state", int'(bus.state), 0);
    checkOutput("rst_fill", int'(bus.fill), 0);
    checkOutput("rst_read_pointer", int'(bus.read_pointer), 0);
    checkOutput("rst_bram_addr", int'(bus.bram_addr), 0);
    checkOutput("rst_bram_we", int'(bus.bram_we), 0);
    checkOutput("rst_timed_out", int'(bus.timed_out), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("held_start_ignored", int'(bus.state), 0);
    bus.request_start = 1'b0;
    @(negedge clk);

`ifdef LA_TIMEOUT_EN
    // No trig: the TMO-th IN_POSITION cycle acts as the trigger.
    applyStimulus(0, 2, TMO - 1, 1'b0);
`else
    // No trig and no timeout: the sequencer waits in IN_POSITION.
    bus.trigger_mode  = 2'd0;
    bus.trigger_loc   = 3'd2;
    bus.trig          = 1'b0;
    bus.request_start = 1'b1;
    @(negedge clk);
    bus.request_start = 1'b0;
    repeat (3 * TMO) @(negedge clk);
    checkOutput("wait_in_position", int'(bus.state), 2);
    checkOutput("wait_fill", int'(bus.fill), 2);
    checkOutput("no_timeout_flag", int'(bus.timed_out), 0);
    bus.request_stop = 1'b1;
    @(negedge clk);
    bus.request_stop = 1'b0;
    checkOutput("abort_wait", int'(bus.state), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
